// File: rtl/seq_bit_serializer_if.sv
// seq_bit_serializer_if: word handshake in, serial bit stream out
interface seq_bit_serializer_if #(parameter int WIDTH = 12);
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic             x_o;
    logic             bit_valid_o;
    logic             last_o;
    logic             busy_o;
    modport master (output data_i, valid_i, input ready_o, x_o, bit_valid_o, last_o, busy_o);
    modport slave  (input data_i, valid_i, output ready_o, x_o, bit_valid_o, last_o, busy_o);
endinterface

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: MSB-first word serializer with one-entry holding buffer
module seq_bit_serializer #(
    parameter int   WIDTH    = 12,
    parameter logic IDLE_BIT = 1'b0
) (
    input logic                clk,
    input logic                reset,
    seq_bit_serializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t            state, state_n;
    logic [WIDTH-1:0]  sreg, sreg_n, hold, hold_n;
    logic              hold_full, hold_full_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              accept;
    assign bus.ready_o     = ~hold_full;
    assign accept          = bus.valid_i & ~hold_full;
    assign bus.x_o         = (state == SHIFT) ? sreg[WIDTH-1] : IDLE_BIT;
    assign bus.bit_valid_o = state == SHIFT;
    assign bus.last_o      = (state == SHIFT) && (cnt == '0);
    assign bus.busy_o      = (state == SHIFT) | hold_full;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sreg      <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            cnt       <= cnt_n;
        end
    end
    // End of word prefers the held word; a same-edge accept is only possible with the hold empty
    always_comb begin
        state_n     = state;
        sreg_n      = sreg;
        hold_n      = hold;
        hold_full_n = hold_full;
        cnt_n       = cnt;
        if (state == IDLE) begin
            if (accept) begin
                sreg_n  = bus.data_i;
                cnt_n   = CW'(WIDTH - 1);
                state_n = SHIFT;
            end
        end else if (cnt == '0) begin
            if (hold_full) begin
                sreg_n      = hold;
                hold_full_n = 1'b0;
                cnt_n       = CW'(WIDTH - 1);
            end else if (accept) begin
                sreg_n = bus.data_i;
                cnt_n  = CW'(WIDTH - 1);
            end else begin
                state_n = IDLE;
            end
        end else begin
            sreg_n = {sreg[WIDTH-2:0], 1'b0};
            cnt_n  = cnt - CW'(1);
            if (accept) begin
                hold_n      = bus.data_i;
                hold_full_n = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: scoreboard bench, expected bit stream queued per accepted word
module tb_seq_bit_serializer;
    localparam int W = 12;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int compared = 0;
    int mismatched = 0;
    logic [1:0] q[$];
    seq_bit_serializer_if #(.WIDTH(W)) bus ();
    seq_bit_serializer_if #(.WIDTH(4)) bus4 ();
    seq_bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (.clk(clk), .reset(reset), .bus(bus));
    seq_bit_serializer #(.WIDTH(4), .IDLE_BIT(1'b1)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: every accepted word contributes WIDTH bits, MSB first, to one continuous stream
    always @(posedge clk)
        if (reset && bus.valid_i && bus.ready_o)
            for (int i = W - 1; i >= 0; i--) q.push_back({bus.data_i[i], i == 0});

    // Pending bits imply streaming; more than one word pending means the buffer is full
    always @(negedge clk) begin
        if (!reset) q.delete();
        else begin
            chk("ready", bus.ready_o, q.size() <= W);
            chk("busy", bus.busy_o, q.size() > 0);
            chk("bit_valid", bus.bit_valid_o, q.size() > 0);
            if (q.size() > 0) begin
                logic [1:0] e;
                e = q.pop_front();
                chk("x", bus.x_o, e[1]);
                chk("last", bus.last_o, e[0]);
            end else chk("idle_x", bus.x_o, 0);
        end
    end

    task automatic send(input logic [W-1:0] w, input bit keep);
        int n = 0;
        bus.valid_i = 1'b1;
        bus.data_i  = w;
        forever begin
            @(negedge clk);
            if (bus.ready_o) break;
            if (++n > 200) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] w4;
        int n;
        bus.valid_i  = 1'b0;
        bus.data_i   = '0;
        bus4.valid_i = 1'b0;
        bus4.data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", bus.x_o, 0);
        chk("rst_bv", bus.bit_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_ready", bus.ready_o, 1);
        chk("rst_last", bus.last_o, 0);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(12'hEDB, 0);
        drain();
        send(12'hEDB, 1);
        send(12'h2DB, 0);
        drain();
        send(12'hEDB, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.last_o && n < 50);
        chk("last_seen", bus.last_o, 1);
        bus.valid_i = 1'b1;
        bus.data_i  = 12'h2DB;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        drain();
        send(12'hFFF, 1);
        send(12'h000, 1);
        send(12'hA5A, 0);
        drain();
        send(12'hEDB, 1);
        send(12'h2DB, 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_x", bus.x_o, 0);
        chk("arst_bv", bus.bit_valid_o, 0);
        chk("arst_busy", bus.busy_o, 0);
        chk("arst_ready", bus.ready_o, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        for (int k = 0; k < 40; k++) begin
            send(W'($urandom), $urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.valid_i = 1'b0;
                repeat ($urandom_range(0, 14)) @(posedge clk);
                #1;
            end
        end
        bus.valid_i = 1'b0;
        drain();
        w4 = 4'b0110;
        bus4.valid_i = 1'b1;
        bus4.data_i  = w4;
        @(negedge clk);
        chk("w4_idle_x", bus4.x_o, 1);
        chk("w4_idle_bv", bus4.bit_valid_o, 0);
        @(posedge clk);
        #1;
        bus4.valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("w4_x", bus4.x_o, w4[3-k]);
            chk("w4_bv", bus4.bit_valid_o, 1);
            chk("w4_last", bus4.last_o, k == 3);
        end
        @(negedge clk);
        chk("w4_end_x", bus4.x_o, 1);
        chk("w4_end_bv", bus4.bit_valid_o, 0);
        chk("w4_end_busy", bus4.busy_o, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
